// File: rtl/spi_access_arbiter.sv
// Round-robin arbiter that gives NUM_REQ requesters one-at-a-time access to the HDP register SPI engine.
// Optional watchdog on the engine done pulse is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_access_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 i_clock,
    input  logic                 i_resetN,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [NUM_REQ-1:0]   i_reqWrite,
    input  logic [NUM_REQ*7-1:0] i_reqAddress,
    input  logic [NUM_REQ*8-1:0] i_reqData,
    output logic [NUM_REQ-1:0]   o_ack,
    output logic [7:0]           o_rdata,
    output logic                 o_timeout,
    output logic                 o_busy,
    output logic                 o_spiTxBegin,
    output logic [6:0]           o_spiTxAddress,
    output logic [7:0]           o_spiTxData,
    input  logic                 i_spiTxDone,
    output logic                 o_spiRxBegin,
    output logic [6:0]           o_spiRxAddress,
    input  logic [7:0]           i_spiRxData,
    input  logic                 i_spiRxDone
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             write_q, write_d;
    logic [6:0]       addr_q,  addr_d;
    logic [7:0]       data_q,  data_d;
    logic [7:0]       rdata_q, rdata_d;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    int               cand;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`else
    // Watchdog absent in this build; the parameter only matters when it is enabled.
    if (TIMEOUT_CYCLES < 1) begin : g_unused_timeout
    end
`endif

    // Rotating scan starting just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && i_req[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    owner_d = grant_idx;
                    last_d  = grant_idx;
                    write_d = i_reqWrite[grant_idx];
                    addr_d  = i_reqAddress[grant_idx*7 +: 7];
                    data_d  = i_reqData[grant_idx*8 +: 8];
                    state_d = ST_ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                // Only the done pulse of the op in flight ends the wait.
                if ((write_q && i_spiTxDone) || (!write_q && i_spiRxDone)) begin
                    if (!write_q) begin
                        rdata_d = i_spiRxData;
                    end
                    state_d = ST_RESP;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_resetN) begin
        if (!i_resetN) begin
            state_q <= ST_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        o_ack = '0;
        if (state_q == ST_RESP) begin
            o_ack[owner_q] = 1'b1;
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    assign o_timeout = (state_q == ST_RESP) && timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_busy         = (state_q != ST_IDLE);
    assign o_spiTxBegin   = (state_q == ST_ISSUE) && write_q;
    assign o_spiRxBegin   = (state_q == ST_ISSUE) && !write_q;
    assign o_spiTxAddress = addr_q;
    assign o_spiRxAddress = addr_q;
    assign o_spiTxData    = data_q;
    assign o_rdata        = rdata_q;

endmodule

// File: tb/tb_spi_access_arbiter.sv
// Directed bench for spi_access_arbiter: single ops, contention order, wrong done, reset mid-op,
// and (with SPI_ARB_TIMEOUT_EN) the watchdog abort.
module tb_spi_access_arbiter;

    localparam int NR = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] req_write = '0;
    logic [NR*7-1:0] req_addr = '0;
    logic [NR*8-1:0] req_data = '0;
    logic [NR-1:0] ack;
    logic [7:0]    rdata;
    logic          timeout;
    logic          busy;
    logic          tx_begin;
    logic [6:0]    tx_addr;
    logic [7:0]    tx_data;
    logic          tx_done = 1'b0;
    logic          rx_begin;
    logic [6:0]    rx_addr;
    logic [7:0]    rx_data = '0;
    logic          rx_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_access_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock        (clk),
        .i_resetN       (rst_n),
        .i_req          (req),
        .i_reqWrite     (req_write),
        .i_reqAddress   (req_addr),
        .i_reqData      (req_data),
        .o_ack          (ack),
        .o_rdata        (rdata),
        .o_timeout      (timeout),
        .o_busy         (busy),
        .o_spiTxBegin   (tx_begin),
        .o_spiTxAddress (tx_addr),
        .o_spiTxData    (tx_data),
        .i_spiTxDone    (tx_done),
        .o_spiRxBegin   (rx_begin),
        .o_spiRxAddress (rx_addr),
        .i_spiRxData    (rx_data),
        .i_spiRxDone    (rx_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic wr, input logic [6:0] a, input logic [7:0] d);
        req[k]            = 1'b1;
        req_write[k]      = wr;
        req_addr[k*7 +: 7] = a;
        req_data[k*8 +: 8] = d;
    endtask

    // Advances to the cycle carrying the begin strobe; returns negedges taken.
    task automatic wait_begin(input string tag, input logic wr, output int n);
        n = 0;
        while (!(wr ? tx_begin : rx_begin) && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_begin"}, {31'd0, (wr ? tx_begin : rx_begin)}, 32'd1);
    endtask

    // Called in the ISSUE cycle: completes the transaction through RESP back to IDLE.
    task automatic finish_txn(input string tag, input int k, input logic wr, input logic [7:0] rxd);
        @(negedge clk);
        check_eq({tag, "_strobe_drop"}, {30'd0, tx_begin, rx_begin}, 32'd0);
        check_eq({tag, "_wait_noack"}, {29'd0, ack}, 32'd0);
        if (wr) begin
            tx_done = 1'b1;
        end else begin
            rx_done = 1'b1;
            rx_data = rxd;
        end
        @(negedge clk);
        tx_done = 1'b0;
        rx_done = 1'b0;
        check_eq({tag, "_ack"}, {29'd0, ack}, 32'(1) << k);
        check_eq({tag, "_no_timeout"}, {31'd0, timeout}, 32'd0);
        if (!wr) begin
            check_eq({tag, "_rdata"}, {24'd0, rdata}, {24'd0, rxd});
        end
        req[k] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ack_drop"}, {29'd0, ack}, 32'd0);
        $display("txn %s: req %0d %s addr 0x%02h", tag, k, wr ? "write" : "read", tx_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int n;

        // Reset state
        @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ack", {29'd0, ack}, 32'd0);
        check_eq("rst_strobes", {30'd0, tx_begin, rx_begin}, 32'd0);
        check_eq("rst_rdata", {24'd0, rdata}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // Single write from requester 0
        set_req(0, 1'b1, 7'h01, 8'h02);
        wait_begin("wr0", 1'b1, n);
        check_eq("wr0_latency", 32'(n), 32'd1);
        check_eq("wr0_addr", {25'd0, tx_addr}, 32'h01);
        check_eq("wr0_data", {24'd0, tx_data}, 32'h02);
        check_eq("wr0_no_rx", {31'd0, rx_begin}, 32'd0);
        check_eq("wr0_busy", {31'd0, busy}, 32'd1);
        finish_txn("wr0", 0, 1'b1, 8'h00);
        check_eq("wr0_idle", {31'd0, busy}, 32'd0);

        // Single read from requester 1
        set_req(1, 1'b0, 7'h78, 8'h00);
        wait_begin("rd1", 1'b0, n);
        check_eq("rd1_addr", {25'd0, rx_addr}, 32'h78);
        check_eq("rd1_no_tx", {31'd0, tx_begin}, 32'd0);
        finish_txn("rd1", 1, 1'b0, 8'h20);

        // Wrong done pulse during a write is ignored
        set_req(1, 1'b1, 7'h33, 8'h44);
        wait_begin("wd1", 1'b1, n);
        @(negedge clk);
        rx_done = 1'b1;
        rx_data = 8'h55;
        @(negedge clk);
        rx_done = 1'b0;
        check_eq("wd1_rx_ignored_ack", {29'd0, ack}, 32'd0);
        check_eq("wd1_rx_ignored_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("wd1_still_waiting", {29'd0, ack}, 32'd0);
        check_eq("wd1_rdata_kept", {24'd0, rdata}, 32'h20);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("wd1_ack", {29'd0, ack}, 32'b010);
        check_eq("wd1_rdata_after", {24'd0, rdata}, 32'h20);
        req[1] = 1'b0;
        @(negedge clk);
        $display("txn wd1: req 1 write with stray read-done");

        // Reset while waiting for the engine
        set_req(2, 1'b1, 7'h05, 8'h06);
        wait_begin("rs2", 1'b1, n);
        @(negedge clk);
        check_eq("rs2_busy_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rs2_busy_cleared", {31'd0, busy}, 32'd0);
        check_eq("rs2_ack_cleared", {29'd0, ack}, 32'd0);
        check_eq("rs2_rdata_cleared", {24'd0, rdata}, 32'd0);
        check_eq("rs2_addr_cleared", {25'd0, tx_addr}, 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check_eq("rs2_late_done_ack", {29'd0, ack}, 32'd0);
        check_eq("rs2_late_done_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("rs2_late_done_ack2", {29'd0, ack}, 32'd0);
        $display("txn rs2: reset during wait, late done ignored");

        // Contention from reset: all three requesters
        rst_n = 1'b0;
        set_req(0, 1'b1, 7'h10, 8'hA0);
        set_req(1, 1'b1, 7'h11, 8'hA1);
        set_req(2, 1'b1, 7'h12, 8'hA2);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NR; k++) begin
            wait_begin("ct", 1'b1, n);
            check_eq("ct_grant_addr", {25'd0, tx_addr}, 32'h10 + 32'(k));
            check_eq("ct_grant_data", {24'd0, tx_data}, 32'hA0 + 32'(k));
            finish_txn("ct", k, 1'b1, 8'h00);
        end
        set_req(2, 1'b1, 7'h22, 8'hB2);
        set_req(0, 1'b1, 7'h20, 8'hB0);
        wait_begin("ct2_first", 1'b1, n);
        check_eq("ct2_first_addr", {25'd0, tx_addr}, 32'h20);
        finish_txn("ct2_first", 0, 1'b1, 8'h00);
        wait_begin("ct2_second", 1'b1, n);
        check_eq("ct2_second_addr", {25'd0, tx_addr}, 32'h22);
        finish_txn("ct2_second", 2, 1'b1, 8'h00);

`ifdef SPI_ARB_TIMEOUT_EN
        // Read that completes, then a read the engine never answers
        set_req(0, 1'b0, 7'h2A, 8'h00);
        wait_begin("to_pre", 1'b0, n);
        finish_txn("to_pre", 0, 1'b0, 8'h9C);
        set_req(1, 1'b0, 7'h2B, 8'h00);
        wait_begin("to1", 1'b0, n);
        rx_data = 8'h11;
        @(negedge clk);
        n = 0;
        while (ack == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("to1_cycles", 32'(n), 32'(TO));
        check_eq("to1_ack", {29'd0, ack}, 32'b010);
        check_eq("to1_timeout", {31'd0, timeout}, 32'd1);
        check_eq("to1_rdata_kept", {24'd0, rdata}, 32'h9C);
        req[1] = 1'b0;
        @(negedge clk);
        check_eq("to1_timeout_drop", {31'd0, timeout}, 32'd0);
        $display("txn to1: req 1 read aborted by watchdog");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
